// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 7-segment scan controller: per-digit buffer, blank/drive
// sequencing with a shadow latch per visit, hex decode and one-hot digit enables.
module seg7_scan_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Enable,
  input  logic                  i_Wr_En,
  input  logic [2:0]            i_Wr_Addr,
  input  logic [4:0]            i_Wr_Data,
  output logic [6:0]            o_Segments,
  output logic [NUM_DIGITS-1:0] o_Digit_En,
  output logic [2:0]            o_Digit_Idx,
  output logic                  o_Frame_Done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      BLANK_LOAD   = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]      DRIVE_LOAD   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]            IDX_LAST     = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]            NUM_DIGITS_4 = 4'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] EN_ONE       = NUM_DIGITS'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       shadow_q, shadow_d;
  logic             frame_d;
  logic [6:0]       seg_d;
  logic [NUM_DIGITS-1:0] en_d;

  // Eight physical slots regardless of NUM_DIGITS so any 3-bit index is in range.
  logic [4:0] digit_buf [0:7];

  function automatic logic [6:0] decode(input logic [4:0] val);
    logic [6:0] seg;
    if (val[4]) begin
      seg = 7'h00;
    end else begin
      case (val[3:0])
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        default: seg = 7'h71;
      endcase
    end
    return seg;
  endfunction

  // NOTE: the buffer is reset like any other register because a reset must
  // blank every digit; it stays a small flop array rather than a RAM.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < 8; i++) digit_buf[i] <= 5'b1_0000;
    end else if (i_Wr_En && ({1'b0, i_Wr_Addr} < NUM_DIGITS_4)) begin
      digit_buf[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    if (!i_Enable) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d  = ST_DRIVE;
            cnt_d    = DRIVE_LOAD;
            shadow_d = digit_buf[idx_q];
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            frame_d = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    seg_d = 7'h00;
    en_d  = '0;
    if (state_d == ST_DRIVE) begin
      seg_d = decode(shadow_d);
      en_d  = EN_ONE << idx_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      shadow_q     <= 5'b1_0000;
      o_Segments   <= 7'h00;
      o_Digit_En   <= '0;
      o_Digit_Idx  <= 3'd0;
      o_Frame_Done <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      o_Segments   <= seg_d;
      o_Digit_En   <= en_d;
      o_Digit_Idx  <= idx_d;
      o_Frame_Done <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: a timeline model derived from the
// scan schedule pushes per-cycle expected outputs that are popped after each edge.
module tb_seg7_scan_controller;

  localparam int ND   = 4;
  localparam int SD   = 4;
  localparam int BC   = 2;
  localparam int SLOT = SD + BC;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic [2:0] idx;
    logic       fd;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [6:0] segments;
  logic [3:0] digit_en;
  logic [2:0] digit_idx;
  logic       frame_done;

  int   total = 0;
  int   bad = 0;
  int   tm = 0;
  obs_t sb [$];
  logic [4:0] model_buf [4];
  logic [6:0] lat_seg [4];
  logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Enable(en),
    .i_Wr_En(wr_en),
    .i_Wr_Addr(wr_addr),
    .i_Wr_Data(wr_data),
    .o_Segments(segments),
    .o_Digit_En(digit_en),
    .o_Digit_Idx(digit_idx),
    .o_Frame_Done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // t = cycles since the edge that first saw enable high (0 = idle).
  function automatic obs_t expect_at(input int t);
    obs_t r;
    int s, ph, d;
    r = '0;
    if (t > 0) begin
      s  = (t - 1) / SLOT;
      ph = (t - 1) % SLOT;
      d  = s % ND;
      r.idx = 3'(d);
      if (ph >= BC) begin
        r.en  = 4'(1 << d);
        r.seg = lat_seg[d];
      end
      r.fd = (ph == 0) && (s > 0) && (s % ND == 0);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      model_buf[i] = 5'h10;
      lat_seg[i]   = 7'h00;
    end
    tm = 0;
    sb.delete();
  endtask

  // Push the expectation for the next cycle, drive inputs, advance one edge.
  task automatic step(input logic e_in, input logic we, input logic [2:0] wa,
                      input logic [4:0] wd);
    int tn, d;
    tn = e_in ? tm + 1 : 0;
    if (tn > 0 && ((tn - 1) % SLOT) == BC) begin
      d = ((tn - 1) / SLOT) % ND;
      lat_seg[d] = model_buf[d][4] ? 7'h00 : seg_lut[model_buf[d][3:0]];
    end
    sb.push_back(expect_at(tn));
    tm = tn;
    en = e_in; wr_en = we; wr_addr = wa; wr_data = wd;
    if (we && wa < 3'(ND)) model_buf[wa[1:0]] = wd;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (segments !== 7'h00) begin bad++; $display("FAIL reset_seg: got %h want 00", segments); end
    total++; if (digit_en !== 4'h0) begin bad++; $display("FAIL reset_en: got %b want 0000", digit_en); end
    total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obs_t got, exp;
      step(1'b0, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_idle tm=%0d: got %h want %h", tm, got, exp);
      end
    end
  endtask

  task automatic test_scan_blank();
    for (int i = 0; i < 60; i++) begin
      obs_t got, exp;
      step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL scan_blank tm=%0d: got seg=%h en=%b idx=%0d fd=%b want seg=%h en=%b idx=%0d fd=%b",
                 tm, got.seg, got.en, got.idx, got.fd, exp.seg, exp.en, exp.idx, exp.fd);
      end
    end
  endtask

  task automatic test_digits();
    logic [2:0] wa [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [4:0] wd [5] = '{5'h00, 5'h03, 5'h0A, 5'h0F, 5'h18};
    for (int i = 0; i < 55; i++) begin
      obs_t got, exp;
      if (i < 5) step(1'b0, i > 0, wa[i], wd[i]);
      else       step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL digits tm=%0d: got seg=%h en=%b idx=%0d fd=%b want seg=%h en=%b idx=%0d fd=%b",
                 tm, got.seg, got.en, got.idx, got.fd, exp.seg, exp.en, exp.idx, exp.fd);
      end
    end
  endtask

  task automatic test_shadow();
    for (int i = 0; i < 42; i++) begin
      obs_t got, exp;
      if (i == 0)        step(1'b0, 1'b0, 3'd0, 5'd0);
      else if (tm == 10) step(1'b1, 1'b1, 3'd1, 5'h08);
      else               step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL shadow tm=%0d: got seg=%h en=%b idx=%0d want seg=%h en=%b idx=%0d",
                 tm, got.seg, got.en, got.idx, exp.seg, exp.en, exp.idx);
      end
    end
  endtask

  task automatic test_disable();
    int re_en = 0;
    for (int i = 0; i < 30; i++) begin
      obs_t got, exp;
      if (i == 0 || (re_en == 0 && tm == 16)) begin
        if (i > 0) re_en = 1;
        step(1'b0, 1'b0, 3'd0, 5'd0);
      end else begin
        step(1'b1, 1'b0, 3'd0, 5'd0);
      end
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL disable tm=%0d: got seg=%h en=%b idx=%0d fd=%b want seg=%h en=%b idx=%0d fd=%b",
                 tm, got.seg, got.en, got.idx, got.fd, exp.seg, exp.en, exp.idx, exp.fd);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 3'd0, 5'd0);
    void'(sb.pop_front());
    while (tm < 10) begin
      obs_t got, exp;
      step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL areset_pre tm=%0d: got %h want %h", tm, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (segments !== 7'h00) begin bad++; $display("FAIL areset_seg: got %h want 00", segments); end
    total++; if (digit_en !== 4'h0) begin bad++; $display("FAIL areset_en: got %b want 0000", digit_en); end
    total++; if (digit_idx !== 3'd0) begin bad++; $display("FAIL areset_idx: got %0d want 0", digit_idx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      obs_t got, exp;
      step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL areset_post tm=%0d: got seg=%h en=%b idx=%0d want seg=%h en=%b idx=%0d",
                 tm, got.seg, got.en, got.idx, exp.seg, exp.en, exp.idx);
      end
    end
  endtask

  task automatic test_oob_write();
    logic [2:0] wa [4] = '{3'd0, 3'd5, 3'd4, 3'd7};
    logic [4:0] wd [4] = '{5'h00, 5'h00, 5'h01, 5'h02};
    for (int i = 0; i < 30; i++) begin
      obs_t got, exp;
      if (i < 4) step(1'b0, i > 0, wa[i], wd[i]);
      else       step(1'b1, 1'b0, 3'd0, 5'd0);
      got = {segments, digit_en, digit_idx, frame_done};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL oob_write tm=%0d: got seg=%h en=%b want seg=%h en=%b",
                 tm, got.seg, got.en, exp.seg, exp.en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_blank();
    test_digits();
    test_shadow();
    test_disable();
    test_async_reset();
    test_oob_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
